vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  Receive side of our VGA link: samples HSYNC/VSYNC/8-bit pixel bus, rebuilds (x,y) from sync edges, checks timing lock,
//  and writes one X_SIZE x Y_SIZE window of a frame into a frame-buffer write port on request. Used for loopback
//  self-test of the display path and as the front end of the photo-capture path into on-chip RAM.
// PARAMETERS
//  X_SIZE      128   window width, pixels
//  Y_SIZE      96    window height, lines
//  ADDR_W      14    WR_ADDR width; must satisfy 2^ADDR_W >= X_SIZE*Y_SIZE
//  H_ACT_START 216   clocks from HSYNC falling edge to first active pixel
//  H_ACT_LEN   800   active pixels per line
//  V_ACT_START 27    lines from VSYNC falling edge to first active line
//  V_ACT_LEN   600   active lines per frame
//  LOCK_FRAMES 2     consecutive identical frames required for LOCKED
// PORTS
//  CLK_40M     in  1      pixel clock; all inputs synchronous to it
//  RST_N       in  1      asynchronous, active-low reset
//  HSYNC_IN    in  1      horizontal sync, active low
//  VSYNC_IN    in  1      vertical sync, active low
//  DATA_IN     in  8      pixel data
//  WIN_X       in  16     window origin column, active-area coordinates
//  WIN_Y       in  16     window origin line, active-area coordinates
//  CAP_START   in  1      1-cycle pulse: capture window of next full frame
//  WR_EN       out 1      frame-buffer write strobe
//  WR_ADDR     out ADDR_W row*X_SIZE + col within window
//  WR_DATA     out 8      pixel value
//  CAP_BUSY    out 1      high from accepted CAP_START until DONE/ERR
//  CAP_DONE    out 1      1-cycle pulse: all X_SIZE*Y_SIZE pixels written
//  CAP_ERR     out 1      1-cycle pulse: capture aborted (frame ended early or lock lost)
//  LOCKED      out 1      line length and line count stable
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; counters, lock history, latched window cleared.
//  - Stage 1 registers HSYNC_IN, VSYNC_IN, DATA_IN; edge detect on registered vs previous sample.
//  - hcnt (16b): 0 on HSYNC fall, else +1, saturates at 16'hFFFF. vcnt (16b): 0 on VSYNC fall; +1 on HSYNC fall;
//    simultaneous VSYNC+HSYNC fall -> hcnt=0, vcnt=0. Saturates at 16'hFFFF.
//  - Active: hcnt in [H_ACT_START, H_ACT_START+H_ACT_LEN), vcnt in [V_ACT_START, V_ACT_START+V_ACT_LEN);
//    ax = hcnt-H_ACT_START, ay = vcnt-V_ACT_START.
//  - In window: active && ax-WX in [0,X_SIZE) && ay-WY in [0,Y_SIZE) (WX/WY latched); compare unsigned on full 16b,
//    no wrap: window beyond active area yields no writes for those pixels.
//  - Latency: pixel on DATA_IN at clock n -> WR_EN/WR_ADDR/WR_DATA valid at clock n+2. WR_EN high 1 cycle per pixel.
//  - Lock: at each HSYNC fall, line length (hcnt+1) compared with previous line; at each VSYNC fall, line count
//    compared with previous frame. Any mismatch -> LOCKED=0, match counter cleared. LOCKED=1 after LOCK_FRAMES
//    consecutive VSYNC falls with all lines equal and line count equal. First line/frame after reset never matches.
//  - FSM: IDLE -> ARMED on CAP_START (WIN_X/WIN_Y latched to WX/WY same cycle; CAP_BUSY=1).
//    ARMED -> CAPTURE on VSYNC fall with LOCKED=1; VSYNC fall with LOCKED=0 stays ARMED.
//    CAPTURE -> DONE after write of address X_SIZE*Y_SIZE-1; DONE: CAP_DONE=1 one cycle, CAP_BUSY=0, -> IDLE.
//    CAPTURE -> ERR on next VSYNC fall before last write, or LOCKED falling; ERR: CAP_ERR=1 one cycle, -> IDLE.
//  - CAP_START outside IDLE ignored (no re-latch). WIN_X/WIN_Y changes after latch have no effect.
//  - Writes occur only in CAPTURE; pixels before ARMED->CAPTURE frame start never written.
//  - RST_N low mid-capture: immediate return to reset state, no CAP_DONE/CAP_ERR pulse.
// TESTING
//  - 800x600 timing (1056 clk/line incl. sync 128, 628 lines, sync 4), wait LOCKED, CAP_START, WIN=(0,0), DATA=ax[7:0]
//    -> exactly 12288 WR_EN, first WR_ADDR=0 WR_DATA=0, WR_ADDR=127 WR_DATA=127, then CAP_DONE once.
//  - WIN=(700,550) -> 100 writes/line for 50 lines, no writes with col>=100, CAP_ERR at next VSYNC fall, no CAP_DONE.
//  - CAP_START before LOCKED -> CAP_BUSY=1, stays ARMED, no writes until lock; capture then completes normally.
//  - CAP_START pulsed again mid-CAPTURE with WIN=(5,5) -> ignored; addresses still follow original window.
//  - One line shortened by 10 clocks mid-capture -> LOCKED=0, CAP_ERR pulse, WR_EN stops; relock after 2 good frames.
//  - RST_N low for 3 cycles mid-capture -> all outputs 0, no CAP_DONE/CAP_ERR; LOCKED returns only after 2 frames.

Source files
------------

// File: rtl/vga_capture.sv
// VGA receive front end: rebuilds pixel coordinates from sync edges, tracks timing lock and
// writes one X_SIZE x Y_SIZE window of a frame into a frame-buffer write port on request.
module vga_capture #(
  parameter int X_SIZE      = 128,
  parameter int Y_SIZE      = 96,
  parameter int ADDR_W      = 14,
  parameter int H_ACT_START = 216,
  parameter int H_ACT_LEN   = 800,
  parameter int V_ACT_START = 27,
  parameter int V_ACT_LEN   = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              CLK_40M,
  input  logic              RST_N,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  input  logic [7:0]        DATA_IN,
  input  logic [15:0]       WIN_X,
  input  logic [15:0]       WIN_Y,
  input  logic              CAP_START,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              CAP_BUSY,
  output logic              CAP_DONE,
  output logic              CAP_ERR,
  output logic              LOCKED
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(X_SIZE * Y_SIZE - 1);
  localparam logic [16:0]       H_END     = 17'(H_ACT_START + H_ACT_LEN);
  localparam logic [16:0]       V_END     = 17'(V_ACT_START + V_ACT_LEN);
  localparam logic [7:0]        LOCK_N    = 8'(LOCK_FRAMES);

  logic       hs_r, vs_r, hs_p, vs_p;
  logic [7:0] data_r;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      hs_r   <= 1'b0;
      vs_r   <= 1'b0;
      hs_p   <= 1'b0;
      vs_p   <= 1'b0;
      data_r <= 8'd0;
    end else begin
      hs_r   <= HSYNC_IN;
      vs_r   <= VSYNC_IN;
      hs_p   <= hs_r;
      vs_p   <= vs_r;
      data_r <= DATA_IN;
    end
  end

  logic hs_fall, vs_fall;
  assign hs_fall = hs_p & ~hs_r;
  assign vs_fall = vs_p & ~vs_r;

  // h_nx/v_nx are the coordinates of the pixel currently held in data_r.
  logic [15:0] hcnt, vcnt, h_nx, v_nx;
  assign h_nx = hs_fall ? 16'd0 : ((hcnt == 16'hFFFF) ? hcnt : hcnt + 16'd1);
  assign v_nx = vs_fall ? 16'd0 :
                hs_fall ? ((vcnt == 16'hFFFF) ? vcnt : vcnt + 16'd1) : vcnt;

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      hcnt <= 16'd0;
      vcnt <= 16'd0;
    end else begin
      hcnt <= h_nx;
      vcnt <= v_nx;
    end
  end

  // Lock tracking: lengths are one more than the final count of the line/frame just ended.
  logic [16:0] line_len, frame_len, prev_len, prev_lines;
  logic        prev_len_vld, prev_lines_vld, frame_ok, line_bad, frame_bad;
  logic [7:0]  match_cnt, cnt_inc;

  assign line_len  = {1'b0, hcnt} + 17'd1;
  assign frame_len = {1'b0, vcnt} + 17'd1;
  assign line_bad  = hs_fall && !(prev_len_vld && (line_len == prev_len));
  assign frame_bad = vs_fall && !(prev_lines_vld && (frame_len == prev_lines) && frame_ok && !line_bad);
  assign cnt_inc   = (match_cnt == LOCK_N) ? match_cnt : match_cnt + 8'd1;

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      prev_len       <= 17'd0;
      prev_len_vld   <= 1'b0;
      prev_lines     <= 17'd0;
      prev_lines_vld <= 1'b0;
      frame_ok       <= 1'b0;
      match_cnt      <= 8'd0;
      LOCKED         <= 1'b0;
    end else begin
      if (hs_fall) begin
        prev_len     <= line_len;
        prev_len_vld <= 1'b1;
      end
      if (vs_fall) begin
        prev_lines     <= frame_len;
        prev_lines_vld <= 1'b1;
        frame_ok       <= 1'b1;
      end else if (line_bad) begin
        frame_ok <= 1'b0;
      end
      if (line_bad || frame_bad) begin
        match_cnt <= 8'd0;
        LOCKED    <= 1'b0;
      end else if (vs_fall) begin
        match_cnt <= cnt_inc;
        if (cnt_inc >= LOCK_N) LOCKED <= 1'b1;
      end
    end
  end

  // Window test is unsigned on full width, so a window past the active area simply never hits.
  logic [15:0]       wx, wy, ax, ay, dx, dy;
  logic              h_act, v_act, in_win, wr_go;
  logic [ADDR_W-1:0] win_addr;
  logic [2:0]        state;

  assign h_act    = (h_nx >= 16'(H_ACT_START)) && ({1'b0, h_nx} < H_END);
  assign v_act    = (v_nx >= 16'(V_ACT_START)) && ({1'b0, v_nx} < V_END);
  assign ax       = h_nx - 16'(H_ACT_START);
  assign ay       = v_nx - 16'(V_ACT_START);
  assign dx       = ax - wx;
  assign dy       = ay - wy;
  assign in_win   = h_act && v_act && (ax >= wx) && (dx < 16'(X_SIZE)) &&
                    (ay >= wy) && (dy < 16'(Y_SIZE));
  assign win_addr = ADDR_W'(32'(dy) * 32'(X_SIZE) + 32'(dx));
  assign wr_go    = (state == ST_CAPTURE) && LOCKED && in_win;

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      wx      <= 16'd0;
      wy      <= 16'd0;
      WR_EN   <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= 8'd0;
    end else begin
      WR_EN <= wr_go;
      if (wr_go) begin
        WR_ADDR <= win_addr;
        WR_DATA <= data_r;
      end
      case (state)
        ST_IDLE: if (CAP_START) begin
          wx    <= WIN_X;
          wy    <= WIN_Y;
          state <= ST_ARMED;
        end
        ST_ARMED: if (vs_fall && LOCKED) state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (WR_EN && (WR_ADDR == LAST_ADDR)) state <= ST_DONE;
          else if (vs_fall || !LOCKED)         state <= ST_ERR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign CAP_BUSY = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign CAP_DONE = (state == ST_DONE);
  assign CAP_ERR  = (state == ST_ERR);

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced video timing: window captures from a vector table plus
// hand sequences for early start, ignored restart, short line and reset mid-capture.
module tb_vga_capture;
  localparam int X = 8, Y = 4, AW = 5;
  localparam int HAS = 8, HLEN = 20, VAS = 2, VLEN = 10, LOCKN = 2;
  localparam int HT = 32, HSW = 4, VT = 14, VSW = 2, FRAME = HT * VT;

  logic          CLK_40M = 1'b0;
  logic          RST_N;
  logic          HSYNC_IN, VSYNC_IN, CAP_START;
  logic [7:0]    DATA_IN;
  logic [15:0]   WIN_X, WIN_Y;
  logic          WR_EN, CAP_BUSY, CAP_DONE, CAP_ERR, LOCKED;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;

  vga_capture #(
    .X_SIZE(X), .Y_SIZE(Y), .ADDR_W(AW), .H_ACT_START(HAS), .H_ACT_LEN(HLEN),
    .V_ACT_START(VAS), .V_ACT_LEN(VLEN), .LOCK_FRAMES(LOCKN)
  ) dut (
    .CLK_40M(CLK_40M), .RST_N(RST_N), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .DATA_IN(DATA_IN), .WIN_X(WIN_X), .WIN_Y(WIN_Y), .CAP_START(CAP_START),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CAP_BUSY(CAP_BUSY),
    .CAP_DONE(CAP_DONE), .CAP_ERR(CAP_ERR), .LOCKED(LOCKED)
  );

  always #5 CLK_40M = ~CLK_40M;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int ax, input int ay);
    return 8'(ax + HLEN * ay);
  endfunction

  // Video source; one line can be shortened by 10 clocks on request.
  bit  short_req = 1'b0;
  int  gh = 0, gv = 0, cur_len = HT;
  time pix_time [VLEN][HLEN];

  initial begin
    HSYNC_IN = 1'b1; VSYNC_IN = 1'b1; DATA_IN = 8'd0;
    forever begin
      @(negedge CLK_40M);
      if (gh == 0) begin
        cur_len   = short_req ? HT - 10 : HT;
        short_req = 1'b0;
      end
      HSYNC_IN = (gh < HSW) ? 1'b0 : 1'b1;
      VSYNC_IN = (gv < VSW) ? 1'b0 : 1'b1;
      if (gh >= HAS && gh < HAS + HLEN && gv >= VAS && gv < VAS + VLEN) begin
        DATA_IN = pix_val(gh - HAS, gv - VAS);
        pix_time[gv - VAS][gh - HAS] = $time;
      end else begin
        DATA_IN = 8'hEE;
      end
      gh++;
      if (gh == cur_len) begin
        gh = 0;
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end
    end
  end

  typedef struct { logic [AW-1:0] addr; logic [7:0] data; time t; } act_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] data; int ax; int ay; } exp_t;
  act_t act_q[$];
  exp_t exp_q[$];
  int done_cnt = 0, err_cnt = 0, wr_unlocked = 0;

  always @(negedge CLK_40M) begin
    if (WR_EN) act_q.push_back('{WR_ADDR, WR_DATA, $time});
    if (WR_EN && !LOCKED) wr_unlocked++;
    if (CAP_DONE) done_cnt++;
    if (CAP_ERR) err_cnt++;
  end

  task automatic build_expected(input int wx, input int wy);
    for (int r = 0; r < Y; r++)
      for (int c = 0; c < X; c++)
        if (wx + c < HLEN && wy + r < VLEN)
          exp_q.push_back('{AW'(r * X + c), pix_val(wx + c, wy + r), wx + c, wy + r});
  endtask

  task automatic compare_writes(input string name, input bit full);
    int n;
    if (full) check({name, "_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr[%0d]", name, i), act_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_data[%0d]", name, i), act_q[i].data, exp_q[i].data);
      check($sformatf("%s_lat[%0d]", name, i), act_q[i].t - pix_time[exp_q[i].ay][exp_q[i].ax], 20);
    end
  endtask

  task automatic wait_lock(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!LOCKED && cycles < budget) begin
      @(negedge CLK_40M);
      cycles++;
    end
    check(name, LOCKED, 1);
  endtask

  // action: 0 none, 1 re-pulse CAP_START with (5,5) after first write, 2 shorten a line after 10 writes.
  task automatic run_capture(input string name, input int wx, input int wy, input int action,
                             input int budget, output int nwr, output int ndone, output int nerr);
    int d0, e0;
    bit acted = 1'b0, busy_drop = 1'b0;
    @(posedge CLK_40M);
    act_q.delete();
    exp_q.delete();
    build_expected(wx, wy);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge CLK_40M);
    WIN_X = 16'(wx); WIN_Y = 16'(wy); CAP_START = 1'b1;
    @(negedge CLK_40M);
    CAP_START = 1'b0; WIN_X = 16'd3; WIN_Y = 16'd2;
    check({name, "_busy"}, CAP_BUSY, 1);
    for (int i = 0; i < budget && done_cnt == d0 && err_cnt == e0; i++) begin
      @(negedge CLK_40M);
      #1;
      CAP_START = 1'b0;
      if (action == 1 && !acted && act_q.size() >= 1) begin
        WIN_X = 16'd5; WIN_Y = 16'd5; CAP_START = 1'b1; acted = 1'b1;
      end
      if (action == 2 && !acted && act_q.size() >= 10) begin
        short_req = 1'b1; acted = 1'b1;
      end
      if (!CAP_BUSY && !CAP_DONE && !CAP_ERR) busy_drop = 1'b1;
    end
    CAP_START = 1'b0;
    check({name, "_finished"}, (done_cnt != d0) || (err_cnt != e0), 1);
    check({name, "_busy_end"}, CAP_BUSY, 0);
    check({name, "_busy_held"}, busy_drop, 0);
    repeat (3) @(negedge CLK_40M);
    nwr   = act_q.size();
    ndone = done_cnt - d0;
    nerr  = err_cnt - e0;
  endtask

  typedef struct { int wx; int wy; int exp_wr; int exp_done; int exp_err; } vec_t;

  initial begin
    vec_t vecs[6];
    int   nwr, nd, ne, n0, cyc, d0, e0;
    vecs[0] = '{0, 0, 32, 1, 0};
    vecs[1] = '{12, 6, 32, 1, 0};
    vecs[2] = '{1, 3, 32, 1, 0};
    vecs[3] = '{16, 8, 8, 0, 1};
    vecs[4] = '{20, 0, 0, 0, 1};
    vecs[5] = '{0, 9, 8, 0, 1};

    RST_N = 1'b0; CAP_START = 1'b0; WIN_X = 16'd0; WIN_Y = 16'd0;
    repeat (3) @(negedge CLK_40M);
    check("rst_wr_en", WR_EN, 0);
    check("rst_wr_addr", WR_ADDR, 0);
    check("rst_wr_data", WR_DATA, 0);
    check("rst_busy", CAP_BUSY, 0);
    check("rst_done", CAP_DONE, 0);
    check("rst_err", CAP_ERR, 0);
    check("rst_locked", LOCKED, 0);
    RST_N = 1'b1;
    @(negedge CLK_40M);

    // Start requested before lock: stays armed, then captures normally.
    check("early_unlocked", LOCKED, 0);
    run_capture("early", 0, 0, 0, 12 * FRAME, nwr, nd, ne);
    check("early_done", nd, 1);
    check("early_err", ne, 0);
    compare_writes("early", 1'b1);
    check("early_wr_unlocked", wr_unlocked, 0);

    for (int i = 0; i < 6; i++) begin
      wait_lock($sformatf("vec%0d_lock", i), 6 * FRAME, cyc);
      run_capture($sformatf("vec%0d", i), vecs[i].wx, vecs[i].wy, 0, 3 * FRAME, nwr, nd, ne);
      check($sformatf("vec%0d_nwr", i), nwr, vecs[i].exp_wr);
      check($sformatf("vec%0d_ndone", i), nd, vecs[i].exp_done);
      check($sformatf("vec%0d_nerr", i), ne, vecs[i].exp_err);
      compare_writes($sformatf("vec%0d", i), 1'b1);
    end

    // Second CAP_START during capture must not re-latch the window.
    wait_lock("restart_lock", 6 * FRAME, cyc);
    run_capture("restart", 2, 1, 1, 3 * FRAME, nwr, nd, ne);
    check("restart_done", nd, 1);
    check("restart_err", ne, 0);
    compare_writes("restart", 1'b1);

    // Short line during capture: rows 0..2 land before lock drops at the end of the short line.
    wait_lock("short_lock", 6 * FRAME, cyc);
    run_capture("short", 0, 0, 2, 3 * FRAME, nwr, nd, ne);
    check("short_err", ne, 1);
    check("short_done", nd, 0);
    check("short_unlocked", LOCKED, 0);
    check("short_nwr", nwr, 24);
    compare_writes("short", 1'b0);
    n0 = act_q.size();
    repeat (FRAME) @(negedge CLK_40M);
    check("short_no_more_wr", act_q.size(), n0);
    wait_lock("short_relock", 6 * FRAME, cyc);

    // Reset mid-capture: everything clears at once, no completion pulse, lock rebuilt from scratch.
    @(posedge CLK_40M);
    act_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge CLK_40M);
    WIN_X = 16'd0; WIN_Y = 16'd0; CAP_START = 1'b1;
    @(negedge CLK_40M);
    CAP_START = 1'b0;
    cyc = 0;
    while (act_q.size() < 5 && cyc < 3 * FRAME) begin
      @(negedge CLK_40M);
      cyc++;
    end
    check("rstmid_writes_seen", act_q.size() >= 5, 1);
    RST_N = 1'b0;
    #1;
    check("rstmid_wr_en", WR_EN, 0);
    check("rstmid_busy", CAP_BUSY, 0);
    check("rstmid_locked", LOCKED, 0);
    check("rstmid_addr", WR_ADDR, 0);
    repeat (3) @(negedge CLK_40M);
    RST_N = 1'b1;
    n0 = act_q.size();
    wait_lock("rstmid_relock", 8 * FRAME, cyc);
    check("rstmid_relock_slow", cyc >= 2 * FRAME, 1);
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_no_err", err_cnt - e0, 0);
    check("rstmid_no_wr", act_q.size(), n0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
